// File: rtl/esm_pkg.sv
// Shared definitions for the ESM status-report stream: constants, header layout
// and decoder state encoding.
package esm_pkg;

  localparam logic [31:0] esm_report_magic_num           = 32'h4553_4D52;
  localparam logic [7:0]  esm_report_message_type_status = 8'h01;

  localparam int unsigned ESM_ENABLES_W     = 5;
  localparam int unsigned ESM_STATUS_W      = 12;
  localparam int unsigned ESM_HEADER_WORDS  = 7;

  localparam int unsigned ESM_WORD_MAGIC    = 0;
  localparam int unsigned ESM_WORD_SEQ      = 1;
  localparam int unsigned ESM_WORD_ID       = 2;
  localparam int unsigned ESM_WORD_ENABLES  = 3;
  localparam int unsigned ESM_WORD_STATUS   = 4;
  localparam int unsigned ESM_WORD_TS_HI    = 5;
  localparam int unsigned ESM_WORD_TS_LO    = 6;

  localparam int unsigned ESM_STAT_CH0_DEMUX_GAP       = 0;
  localparam int unsigned ESM_STAT_CH1_DEMUX_GAP       = 1;
  localparam int unsigned ESM_STAT_CH0_DEMUX_OVERFLOW  = 2;
  localparam int unsigned ESM_STAT_CH0_FILTER_OVERFLOW = 3;
  localparam int unsigned ESM_STAT_CH0_MUX_OVERFLOW    = 4;
  localparam int unsigned ESM_STAT_CH0_MUX_UNDERFLOW   = 5;
  localparam int unsigned ESM_STAT_CH0_MUX_COLLISION   = 6;
  localparam int unsigned ESM_STAT_CH1_DEMUX_OVERFLOW  = 7;
  localparam int unsigned ESM_STAT_CH1_FILTER_OVERFLOW = 8;
  localparam int unsigned ESM_STAT_CH1_MUX_OVERFLOW    = 9;
  localparam int unsigned ESM_STAT_CH1_MUX_UNDERFLOW   = 10;
  localparam int unsigned ESM_STAT_CH1_MUX_COLLISION   = 11;

  // Header words 0..6, word 0 in the most significant position.
  typedef struct packed {
    logic [31:0] magic;
    logic [31:0] seq_num;
    logic [7:0]  module_id;
    logic [7:0]  message_type;
    logic [15:0] pad;
    logic [31:0] enables;
    logic [31:0] status;
    logic [63:0] timestamp;
  } esm_status_report_header_t;

  typedef enum logic [1:0] {
    S_HEADER  = 2'd0,
    S_TRAILER = 2'd1,
    S_DISCARD = 2'd2
  } esm_dec_state_e;

endpackage

// File: rtl/esm_sat_counter.sv
// Saturating up-counter: increments on Inc, holds at all-ones.
module esm_sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Inc,
  output logic [WIDTH-1:0] Count
);

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Count <= '0;
    end else if (Inc && (Count != {WIDTH{1'b1}})) begin
      Count <= Count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/esm_status_report_decoder.sv
// Receive-side decoder for ESM status reports: validates framing and header,
// publishes decoded fields with a strobe and keeps sticky flags and counters.
module esm_status_report_decoder
  import esm_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH     = 32,
  parameter logic [7:0]  EXPECTED_MODULE_ID = 8'd99,
  parameter int unsigned PACKET_WORDS       = 64,
  parameter int unsigned COUNTER_WIDTH      = 16
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      Axis_valid,
  output logic                      Axis_ready,
  input  logic [AXI_DATA_WIDTH-1:0] Axis_data,
  input  logic                      Axis_last,
  input  logic                      Clear_sticky,
  output logic                      Report_valid,
  output logic [31:0]               Report_seq_num,
  output logic [ESM_ENABLES_W-1:0]  Report_enables,
  output logic [ESM_STATUS_W-1:0]   Report_status,
  output logic [63:0]               Report_timestamp,
  output logic [ESM_STATUS_W-1:0]   Status_sticky,
  output logic [COUNTER_WIDTH-1:0]  Count_reports,
  output logic [COUNTER_WIDTH-1:0]  Count_ignored,
  output logic [COUNTER_WIDTH-1:0]  Count_err_magic,
  output logic [COUNTER_WIDTH-1:0]  Count_err_length,
  output logic [COUNTER_WIDTH-1:0]  Count_err_seq
);

  localparam int unsigned IDX_W = (PACKET_WORDS > 1) ? $clog2(PACKET_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_WORDS - 1);

  esm_dec_state_e state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [31:0]              seq_q;
  logic [ESM_ENABLES_W-1:0] en_q;
  logic [ESM_STATUS_W-1:0]  st_q;
  logic [63:0]              ts_q;
  logic                     have_prev_q;
  logic [31:0]              prev_seq_q;

  logic beat, at_last_idx, magic_bad, id_bad;
  logic commit_c, inc_magic_c, inc_ignored_c, inc_length_c, seq_gap_c;

  // The block never backpressures; ready only drops while held in reset.
  assign Axis_ready  = Rst_n;
  assign beat        = Axis_valid && Axis_ready;
  assign at_last_idx = (idx_q == LAST_IDX);
  assign magic_bad   = (idx_q == IDX_W'(ESM_WORD_MAGIC)) &&
                       (Axis_data[31:0] != esm_report_magic_num);
  assign id_bad      = (idx_q == IDX_W'(ESM_WORD_ID)) &&
                       ((Axis_data[31:24] != EXPECTED_MODULE_ID) ||
                        (Axis_data[23:16] != esm_report_message_type_status));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= S_HEADER;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next state: any last beat ends the packet and rearms for word 0.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (beat) begin
      case (state_q)
        S_HEADER: begin
          idx_d = idx_q + IDX_W'(1);
          if (Axis_last) begin
            state_d = S_HEADER;
            idx_d   = '0;
          end else if (magic_bad || id_bad) begin
            state_d = S_DISCARD;
          end else if (idx_q == IDX_W'(ESM_WORD_TS_LO)) begin
            state_d = S_TRAILER;
          end
        end
        S_TRAILER: begin
          idx_d = idx_q + IDX_W'(1);
          if (Axis_last) begin
            state_d = S_HEADER;
            idx_d   = '0;
          end else if (at_last_idx) begin
            state_d = S_DISCARD;
          end
        end
        S_DISCARD: begin
          if (Axis_last) begin
            state_d = S_HEADER;
            idx_d   = '0;
          end
        end
        default: begin
          state_d = S_HEADER;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Event outputs: at most one counter event per packet; content errors win.
  always_comb begin
    commit_c      = 1'b0;
    inc_magic_c   = 1'b0;
    inc_ignored_c = 1'b0;
    inc_length_c  = 1'b0;
    if (beat) begin
      case (state_q)
        S_HEADER: begin
          if (magic_bad)      inc_magic_c   = 1'b1;
          else if (id_bad)    inc_ignored_c = 1'b1;
          else if (Axis_last) inc_length_c  = 1'b1;
        end
        S_TRAILER: begin
          if (at_last_idx && Axis_last)     commit_c     = 1'b1;
          else if (at_last_idx || Axis_last) inc_length_c = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign seq_gap_c = commit_c && have_prev_q && (seq_q != 32'd0) &&
                     (seq_q != prev_seq_q + 32'd1);

  // Shadow capture of header fields.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      seq_q <= '0;
      en_q  <= '0;
      st_q  <= '0;
      ts_q  <= '0;
    end else if (beat && (state_q == S_HEADER)) begin
      case (idx_q)
        IDX_W'(ESM_WORD_SEQ):     seq_q        <= Axis_data[31:0];
        IDX_W'(ESM_WORD_ENABLES): en_q         <= Axis_data[ESM_ENABLES_W-1:0];
        IDX_W'(ESM_WORD_STATUS):  st_q         <= Axis_data[ESM_STATUS_W-1:0];
        IDX_W'(ESM_WORD_TS_HI):   ts_q[63:32]  <= Axis_data[31:0];
        IDX_W'(ESM_WORD_TS_LO):   ts_q[31:0]   <= Axis_data[31:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Report_valid     <= 1'b0;
      Report_seq_num   <= '0;
      Report_enables   <= '0;
      Report_status    <= '0;
      Report_timestamp <= '0;
      have_prev_q      <= 1'b0;
      prev_seq_q       <= '0;
    end else begin
      Report_valid <= commit_c;
      if (commit_c) begin
        Report_seq_num   <= seq_q;
        Report_enables   <= en_q;
        Report_status    <= st_q;
        Report_timestamp <= ts_q;
        have_prev_q      <= 1'b1;
        prev_seq_q       <= seq_q;
      end
    end
  end

  // A clear coinciding with a commit leaves exactly the new status.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Status_sticky <= '0;
    end else if (Clear_sticky) begin
      Status_sticky <= commit_c ? st_q : '0;
    end else if (commit_c) begin
      Status_sticky <= Status_sticky | st_q;
    end
  end

  esm_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_reports (
    .Clk(Clk), .Rst_n(Rst_n), .Inc(commit_c), .Count(Count_reports));
  esm_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_ignored (
    .Clk(Clk), .Rst_n(Rst_n), .Inc(inc_ignored_c), .Count(Count_ignored));
  esm_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_magic (
    .Clk(Clk), .Rst_n(Rst_n), .Inc(inc_magic_c), .Count(Count_err_magic));
  esm_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_length (
    .Clk(Clk), .Rst_n(Rst_n), .Inc(inc_length_c), .Count(Count_err_length));
  esm_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_cnt_seq (
    .Clk(Clk), .Rst_n(Rst_n), .Inc(seq_gap_c), .Count(Count_err_seq));

endmodule

// File: tb/tb_esm_status_report_decoder.sv
// Self-checking bench for esm_status_report_decoder: directed table, randomized
// packets against a packet-level model, and reset/saturation sequences.
module tb_esm_status_report_decoder;
  import esm_pkg::*;

  localparam int PW = 64;

  logic        Clk = 1'b0, Rst_n = 1'b0;
  logic        Axis_valid = 1'b0, Axis_last = 1'b0, Clear_sticky = 1'b0;
  logic [31:0] Axis_data = '0;

  logic        Axis_ready, Report_valid;
  logic [31:0] Report_seq_num;
  logic [4:0]  Report_enables;
  logic [11:0] Report_status, Status_sticky;
  logic [63:0] Report_timestamp;
  logic [15:0] Count_reports, Count_ignored, Count_err_magic, Count_err_length, Count_err_seq;

  logic        r4_ready, r4_valid;
  logic [31:0] r4_seq;
  logic [4:0]  r4_en;
  logic [11:0] r4_st, r4_sticky;
  logic [63:0] r4_ts;
  logic [3:0]  c4_rep, c4_ign, c4_magic, c4_len, c4_seq;

  esm_status_report_decoder dut (
    .Clk(Clk), .Rst_n(Rst_n), .Axis_valid(Axis_valid), .Axis_ready(Axis_ready),
    .Axis_data(Axis_data), .Axis_last(Axis_last), .Clear_sticky(Clear_sticky),
    .Report_valid(Report_valid), .Report_seq_num(Report_seq_num),
    .Report_enables(Report_enables), .Report_status(Report_status),
    .Report_timestamp(Report_timestamp), .Status_sticky(Status_sticky),
    .Count_reports(Count_reports), .Count_ignored(Count_ignored),
    .Count_err_magic(Count_err_magic), .Count_err_length(Count_err_length),
    .Count_err_seq(Count_err_seq));

  esm_status_report_decoder #(.COUNTER_WIDTH(4)) dut4 (
    .Clk(Clk), .Rst_n(Rst_n), .Axis_valid(Axis_valid), .Axis_ready(r4_ready),
    .Axis_data(Axis_data), .Axis_last(Axis_last), .Clear_sticky(Clear_sticky),
    .Report_valid(r4_valid), .Report_seq_num(r4_seq), .Report_enables(r4_en),
    .Report_status(r4_st), .Report_timestamp(r4_ts), .Status_sticky(r4_sticky),
    .Count_reports(c4_rep), .Count_ignored(c4_ign), .Count_err_magic(c4_magic),
    .Count_err_length(c4_len), .Count_err_seq(c4_seq));

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] seq;
    logic [4:0]  en;
    logic [11:0] st;
    logic [63:0] ts;
  } rep_t;

  typedef struct {
    logic [31:0] magic;
    logic [31:0] seq;
    logic [7:0]  mid;
    logic [7:0]  mtype;
    int          len;
    bit          rep;
    int          d_magic, d_ign, d_len, d_seq;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  logic [31:0] pkt [0:127];
  int unsigned e_rep, e_magic, e_ign, e_len, e_seq;
  logic [11:0] e_sticky;
  bit          have_prev;
  logic [31:0] prev_seq;
  rep_t        exp_q[$];
  rep_t        mon_e;
  int          n_pulses;
  vec_t        vecs [0:10];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    e_rep = 0; e_magic = 0; e_ign = 0; e_len = 0; e_seq = 0;
    e_sticky = '0; have_prev = 0; prev_seq = '0; n_pulses = 0;
    exp_q.delete();
  endtask

  task automatic build_pkt(input logic [31:0] magic, input logic [31:0] seq,
                           input logic [7:0] mid, input logic [7:0] mtype);
    esm_status_report_header_t h;
    logic [223:0] flat;
    h.magic        = magic;
    h.seq_num      = seq;
    h.module_id    = mid;
    h.message_type = mtype;
    h.pad          = 16'($urandom);
    h.enables      = $urandom;
    h.status       = $urandom;
    h.timestamp    = {$urandom, $urandom};
    flat = h;
    for (int i = 0; i < 7; i++) pkt[i] = flat[(6 - i) * 32 +: 32];
    for (int i = 7; i < 128; i++) pkt[i] = $urandom;
  endtask

  function automatic rep_t pkt_report();
    return {pkt[1], pkt[3][4:0], pkt[4][11:0], pkt[5], pkt[6]};
  endfunction

  // Record an expected commit of the packet currently in pkt[].
  task automatic expect_commit(input bit clr);
    e_rep++;
    have_prev = 1;
    prev_seq  = pkt[1];
    exp_q.push_back(pkt_report());
    e_sticky = (clr ? 12'h0 : e_sticky) | pkt[4][11:0];
  endtask

  // Packet-level reference: classify the whole packet, then apply sequence rules.
  task automatic model_pkt(input int len, input bit clr);
    if (pkt[0] != esm_report_magic_num) e_magic++;
    else if (len >= 3 && (pkt[2][31:24] != 8'd99 || pkt[2][23:16] != esm_report_message_type_status)) e_ign++;
    else if (len != PW) e_len++;
    else begin
      if (have_prev && pkt[1] != 32'd0 && pkt[1] != prev_seq + 32'd1) e_seq++;
      expect_commit(clr);
      return;
    end
    if (clr) e_sticky = '0;
  endtask

  task automatic send_pkt(input int len, input bit clr, input int vpct, input bit with_last);
    int i;
    i = 0;
    while (i < len) begin
      Axis_valid   = (int'($urandom_range(99)) < vpct);
      Axis_data    = pkt[i];
      Axis_last    = with_last && (i == len - 1);
      Clear_sticky = clr && Axis_valid && Axis_last;
      @(posedge Clk); #1;
      if (Axis_valid) i++;
    end
    Axis_valid = 1'b0; Axis_last = 1'b0; Clear_sticky = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic check_counters(input string tag);
    check({tag, ":reports"}, Count_reports, e_rep);
    check({tag, ":pulses"},  n_pulses,      e_rep);
    check({tag, ":ignored"}, Count_ignored, e_ign);
    check({tag, ":magic"},   Count_err_magic, e_magic);
    check({tag, ":length"},  Count_err_length, e_len);
    check({tag, ":seq"},     Count_err_seq, e_seq);
    check({tag, ":sticky"},  Status_sticky, e_sticky);
  endtask

  always @(negedge Clk) begin
    if (Rst_n && Report_valid) begin
      n_pulses++;
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_report: got seq %0h expected no report", Report_seq_num);
      end else begin
        mon_e = exp_q.pop_front();
        check("report_fields", {Report_seq_num, Report_enables, Report_status, Report_timestamp}, mon_e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] M;
    logic [7:0]  ST;
    int len, kind;
    bit clr;
    logic [31:0] seq;
    logic [11:0] st_chk;
    M  = esm_report_magic_num;
    ST = esm_report_message_type_status;

    vecs[0]  = '{M,            32'd0, 8'd99, ST,    64, 1'b1, 0, 0, 0, 0};
    vecs[1]  = '{32'hDEADBEEF, 32'd1, 8'd99, ST,    64, 1'b0, 1, 0, 0, 0};
    vecs[2]  = '{M,            32'd1, 8'd99, ST,    64, 1'b1, 0, 0, 0, 0};
    vecs[3]  = '{M,            32'd2, 8'd7,  ST,    64, 1'b0, 0, 1, 0, 0};
    vecs[4]  = '{M,            32'd2, 8'd99, 8'h02, 64, 1'b0, 0, 1, 0, 0};
    vecs[5]  = '{M,            32'd2, 8'd99, ST,    41, 1'b0, 0, 0, 1, 0};
    vecs[6]  = '{M,            32'd2, 8'd99, ST,    70, 1'b0, 0, 0, 1, 0};
    vecs[7]  = '{M,            32'd2, 8'd99, ST,    64, 1'b1, 0, 0, 0, 0};
    vecs[8]  = '{M,            32'd5, 8'd99, ST,    64, 1'b1, 0, 0, 0, 1};
    vecs[9]  = '{M,            32'd0, 8'd99, ST,    64, 1'b1, 0, 0, 0, 0};
    vecs[10] = '{M,            32'd1, 8'd99, ST,    64, 1'b1, 0, 0, 0, 0};

    reset_model();
    Rst_n = 1'b0;
    idle(3);
    check("reset_ready", Axis_ready, 1'b0);
    check("reset_report", {Report_valid, Report_seq_num, Report_enables, Report_status, Report_timestamp}, '0);
    check_counters("reset");
    Rst_n = 1'b1;
    idle(1);
    check("ready_after_reset", Axis_ready, 1'b1);

    // Nominal: 20 good reports, 80% valid duty.
    for (int s = 0; s < 20; s++) begin
      build_pkt(M, 32'(s), 8'd99, ST);
      model_pkt(PW, 1'b0);
      send_pkt(PW, 1'b0, 80, 1'b1);
      idle(2);
    end
    check("nominal_count", Count_reports, 16'd20);
    check_counters("nominal");

    // Randomized mix, back-to-back allowed.
    for (int p = 0; p < 30; p++) begin
      kind = int'($urandom_range(9));
      case ($urandom_range(3))
        0: seq = 32'd0;
        1: seq = $urandom;
        default: seq = prev_seq + 32'd1;
      endcase
      build_pkt((kind == 0) ? (32'hDEAD0000 | 32'($urandom_range(65535))) : M, seq,
                (kind == 1) ? 8'd7 : 8'd99, (kind == 2) ? 8'h02 : ST);
      len = PW;
      if (kind == 3) len = ($urandom_range(1) == 0) ? int'($urandom_range(63, 1)) : int'($urandom_range(100, 65));
      clr = ($urandom_range(3) == 0);
      model_pkt(len, clr);
      send_pkt(len, clr, int'($urandom_range(100, 50)), 1'b1);
      idle(int'($urandom_range(2)));
    end
    idle(3);
    check_counters("random");

    // Directed table.
    for (int v = 0; v < 11; v++) begin
      build_pkt(vecs[v].magic, vecs[v].seq, vecs[v].mid, vecs[v].mtype);
      e_magic += vecs[v].d_magic;
      e_ign   += vecs[v].d_ign;
      e_len   += vecs[v].d_len;
      e_seq   += vecs[v].d_seq;
      if (vecs[v].rep) expect_commit(1'b0);
      send_pkt(vecs[v].len, 1'b0, 100, 1'b1);
      idle(2);
      check_counters($sformatf("vec%0d", v));
    end

    // Clear_sticky coinciding with a commit.
    build_pkt(M, 32'd2, 8'd99, ST);
    st_chk = pkt[4][11:0];
    model_pkt(PW, 1'b1);
    send_pkt(PW, 1'b1, 100, 1'b1);
    idle(2);
    check("sticky_clear_commit", Status_sticky, st_chk);
    check_counters("sticky_clear");
    Clear_sticky = 1'b1;
    idle(1);
    Clear_sticky = 1'b0;
    e_sticky = '0;
    idle(1);
    check("sticky_clear_idle", Status_sticky, 12'h0);

    // Reset in the middle of a packet.
    build_pkt(M, 32'd3, 8'd99, ST);
    send_pkt(30, 1'b0, 100, 1'b0);
    Rst_n = 1'b0;
    reset_model();
    idle(1);
    check("midreset_ready", Axis_ready, 1'b0);
    check("midreset_report", {Report_valid, Report_seq_num, Report_enables, Report_status, Report_timestamp}, '0);
    check_counters("midreset");
    Rst_n = 1'b1;
    idle(1);
    build_pkt(M, 32'd7, 8'd99, ST);
    model_pkt(PW, 1'b0);
    send_pkt(PW, 1'b0, 90, 1'b1);
    idle(2);
    check_counters("post_reset");

    // Saturation: 20 bad-magic packets.
    for (int b = 0; b < 20; b++) begin
      build_pkt(32'hDEADBEEF, 32'd8, 8'd99, ST);
      model_pkt(PW, 1'b0);
      send_pkt(PW, 1'b0, 100, 1'b1);
      idle(1);
    end
    idle(2);
    check_counters("saturation");
    check("sat_magic_w4", c4_magic, 4'd15);
    check("pending_reports", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
